mem_arbiter_2x1: RTL

Shares one memory port between the fetch unit (requester F) and the data-memory unit (requester D). Requests are granted round-robin and tagged with a requester ID in the downstream opaque field. Responses are steered back by that tag. Per-requester in-flight counters cap outstanding requests so that neither requester can monopolise the memory. The block sits between FetchUnitL3/the memory unit and the single `MemIntf` to the memory/cache.

---
 rtl/mem_arbiter_2x1_pkg.sv | 27 ++
 rtl/mem_arbiter_2x1_in_flight_counter.sv | 29 ++
 rtl/mem_arbiter_2x1.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_2x1_pkg.sv
// Shared types and opaque-tag helpers for the two-requester memory arbiter.
// Requester ids and the tag/untag helpers that place the id just above the requester opaque.
package mem_arbiter_2x1_pkg;

  typedef enum logic {
    ARB_F = 1'b0,
    ARB_D = 1'b1
  } arb_id_t;

  // Helpers work on a fixed wide vector; callers cast to their real opaque width (<= 32).
  localparam int unsigned MAX_OPAQ_BITS = 32;
  typedef logic [MAX_OPAQ_BITS:0] wide_opaque_t;

  function automatic wide_opaque_t tag_opaque(input arb_id_t id,
                                              input logic [MAX_OPAQ_BITS-1:0] opaque,
                                              input logic [5:0] bits);
    wide_opaque_t t;
    t = {1'b0, opaque};
    t[bits] = id;
    return t;
  endfunction

  function automatic arb_id_t opaque_id(input wide_opaque_t t, input logic [5:0] bits);
    return arb_id_t'(t[bits]);
  endfunction

endpackage

// File: rtl/mem_arbiter_2x1_in_flight_counter.sv
// Outstanding-request counter for one requester; saturates at zero on a stray response.
module mem_arbiter_2x1_in_flight_counter #(
  parameter  int p_max = 16,
  localparam int CW    = $clog2(p_max + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign at_max = (count == CW'(p_max));

  // A response with nothing outstanding means the memory side is broken.
  underflow_check : assert property (@(posedge clk) disable iff (!rst) !(dec && count == '0));

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Round-robin arbiter sharing one memory port between fetch (F) and data (D) requesters.
// Handshake: a transfer happens in a cycle where val && rdy are both high; rdy may depend on val only through the grant.
module mem_arbiter_2x1
  import mem_arbiter_2x1_pkg::*;
#(
  parameter  int p_opaq_bits     = 8,
  parameter  int p_max_in_flight = 16,
  localparam int OW              = p_opaq_bits + 1,
  localparam int CW              = $clog2(p_max_in_flight + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_req_val,
  output logic                   f_req_rdy,
  input  logic                   f_req_op,
  input  logic [p_opaq_bits-1:0] f_req_opaque,
  input  logic [31:0]            f_req_addr,
  input  logic [31:0]            f_req_data,
  output logic                   f_resp_val,
  input  logic                   f_resp_rdy,
  output logic                   f_resp_op,
  output logic [p_opaq_bits-1:0] f_resp_opaque,
  output logic [31:0]            f_resp_data,
  input  logic                   d_req_val,
  output logic                   d_req_rdy,
  input  logic                   d_req_op,
  input  logic [p_opaq_bits-1:0] d_req_opaque,
  input  logic [31:0]            d_req_addr,
  input  logic [31:0]            d_req_data,
  output logic                   d_resp_val,
  input  logic                   d_resp_rdy,
  output logic                   d_resp_op,
  output logic [p_opaq_bits-1:0] d_resp_opaque,
  output logic [31:0]            d_resp_data,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic                   mem_req_op,
  output logic [OW-1:0]          mem_req_opaque,
  output logic [31:0]            mem_req_addr,
  output logic [31:0]            mem_req_data,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic                   mem_resp_op,
  input  logic [OW-1:0]          mem_resp_opaque,
  input  logic [31:0]            mem_resp_data,
  output logic [CW-1:0]          f_count,
  output logic [CW-1:0]          d_count
);

  logic                   f_at_max, d_at_max;
  logic                   elig_f, elig_d;
  arb_id_t                winner, last_grant, resp_id;
  logic [p_opaq_bits-1:0] win_opaque;

  always_comb begin
    elig_f = f_req_val && !f_at_max;
    elig_d = d_req_val && !d_at_max;
    winner = ARB_F;
    if (elig_d && (!elig_f || last_grant == ARB_F)) begin
      winner = ARB_D;
    end
  end

  assign mem_req_val = elig_f || elig_d;
  // The at_max gate keeps an idle-default winner from seeing rdy while blocked.
  assign f_req_rdy   = mem_req_rdy && (winner == ARB_F) && !f_at_max;
  assign d_req_rdy   = mem_req_rdy && (winner == ARB_D) && !d_at_max;

  assign mem_req_op     = (winner == ARB_D) ? d_req_op   : f_req_op;
  assign mem_req_addr   = (winner == ARB_D) ? d_req_addr : f_req_addr;
  assign mem_req_data   = (winner == ARB_D) ? d_req_data : f_req_data;
  assign win_opaque     = (winner == ARB_D) ? d_req_opaque : f_req_opaque;
  assign mem_req_opaque = OW'(tag_opaque(winner, 32'(win_opaque), 6'(p_opaq_bits)));

  assign resp_id       = opaque_id(wide_opaque_t'(mem_resp_opaque), 6'(p_opaq_bits));
  assign f_resp_val    = mem_resp_val && (resp_id == ARB_F);
  assign d_resp_val    = mem_resp_val && (resp_id == ARB_D);
  assign mem_resp_rdy  = (resp_id == ARB_D) ? d_resp_rdy : f_resp_rdy;
  assign f_resp_op     = mem_resp_op;
  assign d_resp_op     = mem_resp_op;
  assign f_resp_opaque = mem_resp_opaque[p_opaq_bits-1:0];
  assign d_resp_opaque = mem_resp_opaque[p_opaq_bits-1:0];
  assign f_resp_data   = mem_resp_data;
  assign d_resp_data   = mem_resp_data;

  // Reset to D so F takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= ARB_D;
    end else if (mem_req_val && mem_req_rdy) begin
      last_grant <= winner;
    end
  end

  mem_arbiter_2x1_in_flight_counter #(.p_max(p_max_in_flight)) u_f_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (f_req_val && f_req_rdy),
    .dec    (f_resp_val && f_resp_rdy),
    .count  (f_count),
    .at_max (f_at_max)
  );

  mem_arbiter_2x1_in_flight_counter #(.p_max(p_max_in_flight)) u_d_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (d_req_val && d_req_rdy),
    .dec    (d_resp_val && d_resp_rdy),
    .count  (d_count),
    .at_max (d_at_max)
  );

endmodule
